lr_seq_ctrl: RTL and testbench

Parametrised sequencing controller for the linear-regression datapath. It takes a start request, walks the sample memory once to accumulate Σx, Σy, Σxy and Σx², and then sequences the coefficient arithmetic for b1 and b0. A multi-cycle divider is driven through a go/done handshake, and an optional second sweep accumulates the fit error. It sits between the top-level start/ready interface and the datapath, and replaces fixed-length external sample counters with an internal, parameter-sized counter.

---
 rtl/lr_seq_ctrl_if.sv | 28 ++
 rtl/lr_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_lr_seq_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lr_seq_ctrl_if.sv
// Handshake and control bundle between lr_seq_ctrl (master) and the datapath/top level (slave).
interface lr_seq_ctrl_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              start;
   logic              abort;
   logic              div_done;
   logic              ready;
   logic              done;
   logic [ADDR_W-1:0] addr;
   logic              clr;
   logic              acc_en;
   logic [2:0]        op;
   logic              div_go;
   logic              ld_b1;
   logic              ld_b0;
   logic              err_en;

   modport master (
      input  start, abort, div_done,
      output ready, done, addr, clr, acc_en, op, div_go, ld_b1, ld_b0, err_en
   );

   modport slave (
      output start, abort, div_done,
      input  ready, done, addr, clr, acc_en, op, div_go, ld_b1, ld_b0, err_en
   );
endinterface

// File: rtl/lr_seq_ctrl.sv
// Linear-regression sequencer: sample sweep, b1/b0 coefficient steps with divider handshake.
// Define LR_ERR_EN to add the residual-error sweep (ERR state, err_en).
module lr_seq_ctrl #(
   parameter int unsigned N_SAMPLES = 150,
   parameter int unsigned ADDR_W    = 8
) (
   input logic           clk,
   input logic           rst,
   lr_seq_ctrl_if.master bus
);
   localparam int unsigned OP_W = 3;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

   localparam logic [OP_W-1:0] OP_NOP    = 3'd0;
   localparam logic [OP_W-1:0] OP_MUL_A  = 3'd1;
   localparam logic [OP_W-1:0] OP_SUB_A  = 3'd2;
   localparam logic [OP_W-1:0] OP_DIV_B1 = 3'd3;
   localparam logic [OP_W-1:0] OP_MUL_B  = 3'd4;
   localparam logic [OP_W-1:0] OP_SUB_B  = 3'd5;
   localparam logic [OP_W-1:0] OP_DIV_B0 = 3'd6;
`ifdef LR_ERR_EN
   localparam logic [OP_W-1:0] OP_ERR    = 3'd7;
`endif

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLR,
      S_ACC,
      S_MUL,
      S_SUB,
      S_DIV1,
      S_DIV1_W,
      S_MULB,
      S_SUBB,
      S_DIV0,
      S_DIV0_W,
`ifdef LR_ERR_EN
      S_ERR,
`endif
      S_FIN
   } state_e;

   state_e            state_d, state_q;
   logic [ADDR_W-1:0] addr_d, addr_q;
   logic              ready_d, ready_q;
   logic              done_d, done_q;
   logic              clr_d, clr_q;
   logic              acc_en_d, acc_en_q;
   logic              div_go_d, div_go_q;
   logic [OP_W-1:0]   op_d, op_q;
   logic              sweep_c;
`ifdef LR_ERR_EN
   logic              err_en_d, err_en_q;
`endif

   // Next state; abort overrides every transition out of a non-idle state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (bus.start) state_d = S_CLR;
         S_CLR:    state_d = S_ACC;
         S_ACC:    if (addr_q == LAST_ADDR) state_d = S_MUL;
         S_MUL:    state_d = S_SUB;
         S_SUB:    state_d = S_DIV1;
         S_DIV1:   state_d = S_DIV1_W;
         S_DIV1_W: if (bus.div_done) state_d = S_MULB;
         S_MULB:   state_d = S_SUBB;
         S_SUBB:   state_d = S_DIV0;
         S_DIV0:   state_d = S_DIV0_W;
`ifdef LR_ERR_EN
         S_DIV0_W: if (bus.div_done) state_d = S_ERR;
         S_ERR:    if (addr_q == LAST_ADDR) state_d = S_FIN;
`else
         S_DIV0_W: if (bus.div_done) state_d = S_FIN;
`endif
         S_FIN:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (bus.abort && (state_q != S_IDLE)) state_d = S_IDLE;
   end

   // Sample index counts only while staying in a sweep state, otherwise returns to zero.
   always_comb begin
      sweep_c = (state_q == S_ACC);
`ifdef LR_ERR_EN
      sweep_c = sweep_c || (state_q == S_ERR);
`endif
      addr_d = (sweep_c && (state_d == state_q)) ? addr_q + ADDR_W'(1) : '0;
   end

   // Moore outputs decoded from the next state so the registers line up with the state.
   always_comb begin
      ready_d  = 1'b0;
      done_d   = 1'b0;
      clr_d    = 1'b0;
      acc_en_d = 1'b0;
      div_go_d = 1'b0;
      op_d     = OP_NOP;
`ifdef LR_ERR_EN
      err_en_d = 1'b0;
`endif
      case (state_d)
         S_IDLE:   ready_d = 1'b1;
         S_CLR:    clr_d = 1'b1;
         S_ACC:    acc_en_d = 1'b1;
         S_MUL:    op_d = OP_MUL_A;
         S_SUB:    op_d = OP_SUB_A;
         S_DIV1: begin
            op_d     = OP_DIV_B1;
            div_go_d = 1'b1;
         end
         S_DIV1_W: op_d = OP_DIV_B1;
         S_MULB:   op_d = OP_MUL_B;
         S_SUBB:   op_d = OP_SUB_B;
         S_DIV0: begin
            op_d     = OP_DIV_B0;
            div_go_d = 1'b1;
         end
         S_DIV0_W: op_d = OP_DIV_B0;
`ifdef LR_ERR_EN
         S_ERR: begin
            op_d     = OP_ERR;
            err_en_d = 1'b1;
         end
`endif
         S_FIN:    done_d = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         clr_q    <= 1'b0;
         acc_en_q <= 1'b0;
         div_go_q <= 1'b0;
         op_q     <= OP_NOP;
`ifdef LR_ERR_EN
         err_en_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         clr_q    <= clr_d;
         acc_en_q <= acc_en_d;
         div_go_q <= div_go_d;
         op_q     <= op_d;
`ifdef LR_ERR_EN
         err_en_q <= err_en_d;
`endif
      end
   end

   assign bus.ready  = ready_q;
   assign bus.done   = done_q;
   assign bus.addr   = addr_q;
   assign bus.clr    = clr_q;
   assign bus.acc_en = acc_en_q;
   assign bus.op     = op_q;
   assign bus.div_go = div_go_q;
`ifdef LR_ERR_EN
   assign bus.err_en = err_en_q;
`else
   assign bus.err_en = 1'b0;
`endif

   // Coefficient loads follow div_done in the same cycle; an abort suppresses them.
   assign bus.ld_b1 = (state_q == S_DIV1_W) && bus.div_done && !bus.abort;
   assign bus.ld_b0 = (state_q == S_DIV0_W) && bus.div_done && !bus.abort;
endmodule

// File: tb/tb_lr_seq_ctrl.sv
// Bench for lr_seq_ctrl: cycle-schedule reference model, scenario table and randomized runs.
module tb_lr_seq_ctrl;
`ifdef LR_ERR_EN
   localparam bit ERR_ON = 1'b1;
`else
   localparam bit ERR_ON = 1'b0;
`endif

   typedef struct packed {
      logic       ready;
      logic       done;
      logic [7:0] addr;
      logic       clr;
      logic       acc_en;
      logic [2:0] op;
      logic       div_go;
      logic       ld_b1;
      logic       ld_b0;
      logic       err_en;
   } out_t;

   typedef struct {
      int w1;
      int w0;
      int abort_at;
      int rst_at;
      int mode;
      bit hold;
      int exp_b1;
      int exp_b0;
      int exp_done;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sel = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic div_done = 1'b0;
   out_t obs;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   lr_seq_ctrl_if #(.ADDR_W(3)) if4 ();
   lr_seq_ctrl_if #(.ADDR_W(8)) if256 ();

   lr_seq_ctrl #(.N_SAMPLES(4), .ADDR_W(3)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.master));
   lr_seq_ctrl #(.N_SAMPLES(256), .ADDR_W(8)) u_dut256 (.clk(clk), .rst(rst), .bus(if256.master));

   assign if4.start      = start & ~sel;
   assign if4.abort      = abort & ~sel;
   assign if4.div_done   = div_done & ~sel;
   assign if256.start    = start & sel;
   assign if256.abort    = abort & sel;
   assign if256.div_done = div_done & sel;

   always_comb begin
      if (sel)
         obs = out_t'({if256.ready, if256.done, if256.addr, if256.clr, if256.acc_en, if256.op,
                       if256.div_go, if256.ld_b1, if256.ld_b0, if256.err_en});
      else
         obs = out_t'({if4.ready, if4.done, 8'(if4.addr), if4.clr, if4.acc_en, if4.op,
                       if4.div_go, if4.ld_b1, if4.ld_b0, if4.err_en});
   end

   function automatic out_t idle_exp();
      out_t e = '0;
      e.ready = 1'b1;
      return e;
   endfunction

   // Expected outputs at cycle t of an uninterrupted run, from the published cycle schedule.
   function automatic out_t exp_at(int n, int t, int w1, int w0);
      out_t e = '0;
      int div1 = n + 4;
      int div0 = n + 7 + w1;
      int err0 = n + 8 + w1 + w0;
      int fin  = err0 + (ERR_ON ? n : 0);
      if (t <= 0 || t > fin) e.ready = 1'b1;
      else if (t == 1) e.clr = 1'b1;
      else if (t <= n + 1) begin e.acc_en = 1'b1; e.addr = 8'(t - 2); end
      else if (t == n + 2) e.op = 3'd1;
      else if (t == n + 3) e.op = 3'd2;
      else if (t <= div1 + w1) begin
         e.op = 3'd3; e.div_go = (t == div1); e.ld_b1 = (t == div1 + w1);
      end
      else if (t == div1 + w1 + 1) e.op = 3'd4;
      else if (t == div1 + w1 + 2) e.op = 3'd5;
      else if (t <= div0 + w0) begin
         e.op = 3'd6; e.div_go = (t == div0); e.ld_b0 = (t == div0 + w0);
      end
      else if (t < fin) begin e.op = 3'd7; e.err_en = 1'b1; e.addr = 8'(t - err0); end
      else e.done = 1'b1;
      return e;
   endfunction

   task automatic chk(input out_t e, input string tag, input int t, output out_t got);
      got = obs;
      checks++;
      if (got !== e) begin
         failures++;
         $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, e);
      end
   endtask

   // One cycle: inputs driven just after the rising edge, outputs checked at the falling edge.
   task automatic cyc(input logic s, input logic a, input logic d, input out_t e,
                      input string tag, input int t, output out_t got);
      start = s; abort = a; div_done = d;
      @(negedge clk);
      chk(e, tag, t, got);
      @(posedge clk);
      #1;
   endtask

   task automatic run(input logic s1, input int n, input int w1, input int w0,
                      input int abort_at, input int rst_at, input int mode,
                      input bit hold, input bit b2b, input string tag,
                      output int ev_b1, output int ev_b0, output int ev_done);
      int   div1 = n + 4;
      int   div0 = n + 7 + w1;
      int   fin  = n + 8 + w1 + w0 + (ERR_ON ? n : 0);
      int   last;
      out_t e, got;
      logic s, a, d;
      sel = s1;
      ev_b1 = -1; ev_b0 = -1; ev_done = -1;
      last = fin;
      if (abort_at >= 0) last = abort_at;
      if (rst_at >= 0) last = rst_at;
      for (int t = 0; t <= last; t++) begin
         s = (t == 0) ? 1'b1 : (hold ? 1'($urandom) : 1'b0);
         a = (t == abort_at);
         if (mode == 2) d = 1'b1;
         else if (t > div1 && t <= div1 + w1) d = (t == div1 + w1);
         else if (t > div0 && t <= div0 + w0) d = (t == div0 + w0);
         else d = (mode == 1) ? 1'($urandom) : 1'b0;
         e = exp_at(n, t, w1, w0);
         if (a) begin e.ld_b1 = 1'b0; e.ld_b0 = 1'b0; end
         if (t == rst_at) begin
            start = s; abort = a; div_done = d;
            #2 rst = 1'b1;
            #1 chk(idle_exp(), {tag, "_rst"}, t, got);
            @(posedge clk);
            #1 rst = 1'b0;
         end else begin
            cyc(s, a, d, e, tag, t, got);
            if (got.ld_b1 && ev_b1 < 0) ev_b1 = t;
            if (got.ld_b0 && ev_b0 < 0) ev_b0 = t;
            if (got.done && ev_done < 0) ev_done = t;
         end
      end
      // Trailing idle cycle: abort and div_done must be ignored here.
      if (rst_at < 0 && (abort_at >= 0 || !b2b))
         cyc(1'b0, 1'($urandom), 1'($urandom), idle_exp(), {tag, "_idle"}, last + 1, got);
   endtask

   vec_t vt[7];

   initial begin
      out_t got;
      int   b1, b0, dn;

      vt[0] = '{3, 3, -1, -1, 0, 1'b0, 11, 17, ERR_ON ? 22 : 18};
      vt[1] = '{1, 1, -1, -1, 2, 1'b0, 9, 13, ERR_ON ? 18 : 14};
      vt[2] = '{2, 5, -1, -1, 1, 1'b1, 10, 18, ERR_ON ? 23 : 19};
      vt[3] = '{3, 3, 3, -1, 0, 1'b0, -1, -1, -1};
      vt[4] = '{1, 2, -1, -1, 0, 1'b0, 9, 14, ERR_ON ? 19 : 15};
      vt[5] = '{2, 3, 10, -1, 1, 1'b0, -1, -1, -1};
      vt[6] = '{1, 3, -1, 14, 0, 1'b0, 9, -1, -1};

      sel = 1'b0;
      @(negedge clk);
      chk(idle_exp(), "reset4", 0, got);
      sel = 1'b1;
      #1 chk(idle_exp(), "reset256", 0, got);
      @(posedge clk);
      #1 rst = 1'b0;
      sel = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run(1'b0, 4, vt[i].w1, vt[i].w0, vt[i].abort_at, vt[i].rst_at, vt[i].mode,
             vt[i].hold, 1'b0, $sformatf("vec%0d", i), b1, b0, dn);
         checks += 3;
         if (b1 != vt[i].exp_b1) begin
            failures++; $display("FAIL vec%0d_ld_b1 cycle got=%0d exp=%0d", i, b1, vt[i].exp_b1);
         end
         if (b0 != vt[i].exp_b0) begin
            failures++; $display("FAIL vec%0d_ld_b0 cycle got=%0d exp=%0d", i, b0, vt[i].exp_b0);
         end
         if (dn != vt[i].exp_done) begin
            failures++; $display("FAIL vec%0d_done cycle got=%0d exp=%0d", i, dn, vt[i].exp_done);
         end
      end

      for (int r = 0; r < 30; r++) begin
         int w1 = int'($urandom_range(4, 1));
         int w0 = int'($urandom_range(4, 1));
         int fin = 4 + 8 + w1 + w0 + (ERR_ON ? 4 : 0);
         int ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(fin, 1)) : -1;
         run(1'b0, 4, w1, w0, ab, -1, int'($urandom_range(1, 0)), 1'($urandom),
             (r != 29) && 1'($urandom), $sformatf("rnd%0d", r), b1, b0, dn);
      end

      run(1'b1, 256, 2, 1, -1, -1, 1, 1'b1, 1'b0, "n256", b1, b0, dn);
      checks++;
      if (b1 != 256 + 4 + 2) begin
         failures++; $display("FAIL n256_ld_b1 cycle got=%0d exp=%0d", b1, 256 + 6);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
